// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780-style text LCD controller.
package lcd_pkg;

  typedef enum logic [2:0] {StInit, StClrWait, StRowAddr, StChars, StIdle} lcd_state_e;
  typedef enum logic [1:0] {PhIdle, PhSetup, PhPulse, PhHold} phy_phase_e;

  localparam logic [7:0] CmdFuncSet   = 8'h38;
  localparam logic [7:0] CmdDispOn    = 8'h0C;
  localparam logic [7:0] CmdEntryMode = 8'h06;
  localparam logic [7:0] CmdClear     = 8'h01;

  localparam logic [3:0][7:0] InitCmds = {CmdClear, CmdEntryMode, CmdDispOn, CmdFuncSet};
  localparam logic [3:0][7:0] RowBase  = {8'hD4, 8'h94, 8'hC0, 8'h80};

  // DATA bus fields: [15:14] row, [13:8] column, [7:0] character
  localparam int unsigned RowLsb  = 14;
  localparam int unsigned RowBits = 2;
  localparam int unsigned ColLsb  = 8;
  localparam int unsigned ColBits = 6;
  localparam int unsigned ChrLsb  = 0;

  function automatic logic [7:0] row_base(input logic [1:0] row);
    return RowBase[row];
  endfunction

endpackage

// File: rtl/lcd_bus_phy.sv
// Write-only LCD bus phase engine: SETUP / PULSE / HOLD, each TICK cycles long.
module lcd_bus_phy
  import lcd_pkg::*;
#(
  parameter int unsigned TICK = 4096
) (
  input  logic       clk_LCD,
  input  logic       rst,
  input  logic       start,
  input  logic       rs,
  input  logic [7:0] data_byte,
  output logic       LCD_EN,
  output logic       RS,
  output logic [7:0] DB8,
  output logic       done
);

  localparam int unsigned TickW = $clog2(TICK);

  phy_phase_e       phase_q, phase_d;
  logic [TickW-1:0] cnt_q, cnt_d;
  logic             rs_q;
  logic [7:0]       db_q;
  logic             tick_end;
  logic             load;

  assign tick_end = (cnt_q == TickW'(TICK - 1));
  assign done     = (phase_q == PhHold) && tick_end;
  // A new start is taken on the last HOLD cycle so transfers run back to back.
  assign load     = start && ((phase_q == PhIdle) || done);

  always_comb begin
    phase_d = phase_q;
    cnt_d   = cnt_q;
    if (phase_q != PhIdle) begin
      if (tick_end) begin
        cnt_d = '0;
        unique case (phase_q)
          PhSetup: phase_d = PhPulse;
          PhPulse: phase_d = PhHold;
          default: phase_d = PhIdle;
        endcase
      end else begin
        cnt_d = cnt_q + TickW'(1);
      end
    end
    if (load) begin
      phase_d = PhSetup;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk_LCD) begin
    if (!rst) begin
      phase_q <= PhIdle;
      cnt_q   <= '0;
      rs_q    <= 1'b0;
      db_q    <= 8'h00;
    end else begin
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      if (load) begin
        rs_q <= rs;
        db_q <= data_byte;
      end
    end
  end

  // Gated by rst so an aborted transfer drops the strobe in the reset cycle itself.
  assign LCD_EN = rst & (phase_q == PhPulse);
  assign RS     = rs_q;
  assign DB8    = db_q;

endmodule

// File: rtl/lcd_text_ctrl.sv
// ROWS x COLS character-LCD controller: bus-written buffer, init and refresh sequencer.
// Define LCD_DIRTY_SKIP_EN to refresh only rows written since their last refresh.
module lcd_text_ctrl
  import lcd_pkg::*;
#(
  parameter int unsigned COLS     = 16,
  parameter int unsigned ROWS     = 2,
  parameter logic [15:0] DEV_ADDR = 16'h0071,
  parameter int unsigned TICK     = 4096,
  parameter int unsigned CLR_WAIT = 32768
) (
  input  logic        clk_LCD,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [15:0] DEVICE,
  input  logic [15:0] DATA,
  output logic        LCD_EN,
  output logic        RS,
  output logic        RW,
  output logic [7:0]  DB8,
  output logic        frame_done,
  output logic        wr_err
);

  localparam int unsigned RowW  = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned ColW  = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int unsigned WaitW = $clog2(CLR_WAIT + 1);

  logic [RowBits-1:0] wr_row;
  logic [ColBits-1:0] wr_col;
  logic [7:0]         wr_chr;
  logic               wr_hit, in_range, wr_ok;

  assign wr_row   = DATA[RowLsb +: RowBits];
  assign wr_col   = DATA[ColLsb +: ColBits];
  assign wr_chr   = DATA[ChrLsb +: 8];
  assign wr_hit   = wr_en && (DEVICE == DEV_ADDR);
  assign in_range = ({1'b0, wr_row} < 3'(ROWS)) && ({1'b0, wr_col} < 7'(COLS));
  assign wr_ok    = wr_hit && in_range;

  logic [7:0] char_q [ROWS][COLS];

  always_ff @(posedge clk_LCD) begin
    if (!rst) begin
      for (int unsigned r = 0; r < ROWS; r++) begin
        for (int unsigned c = 0; c < COLS; c++) begin
          char_q[r][c] <= 8'h20;
        end
      end
    end else if (wr_ok) begin
      char_q[wr_row[RowW-1:0]][wr_col[ColW-1:0]] <= wr_chr;
    end
  end

  lcd_state_e       state_q, state_d;
  logic [1:0]       step_q, step_d;
  logic [RowW-1:0]  row_q, row_d, next_row;
  logic [ColW-1:0]  col_q, col_d;
  logic [WaitW-1:0] wait_q, wait_d;
  logic             busy_q, pend_q, pend_d, frame_done_q, frame_done_d, wr_err_q;
  logic             start, xfer_rs, phy_done, ready, last_row;
  logic [7:0]       xfer_byte;

  assign ready    = ~busy_q | phy_done;
  assign last_row = (row_q == RowW'(ROWS - 1));
  assign next_row = last_row ? '0 : row_q + RowW'(1);

`ifdef LCD_DIRTY_SKIP_EN
  logic [ROWS-1:0] dirty_q, dirty_d;

  // A write in the same cycle as the row's address transfer leaves the row dirty.
  always_comb begin
    dirty_d = dirty_q;
    if (start && (state_q == StRowAddr)) dirty_d[row_q] = 1'b0;
    if (wr_ok) dirty_d[wr_row[RowW-1:0]] = 1'b1;
  end

  always_ff @(posedge clk_LCD) begin
    if (!rst) dirty_q <= '1;
    else      dirty_q <= dirty_d;
  end
`endif

  always_comb begin
    state_d      = state_q;
    step_d       = step_q;
    row_d        = row_q;
    col_d        = col_q;
    wait_d       = wait_q;
    pend_d       = pend_q & ~phy_done;
    frame_done_d = pend_q & phy_done;
    start        = 1'b0;
    xfer_rs      = 1'b0;
    xfer_byte    = 8'h00;
    unique case (state_q)
      StInit: begin
        if (ready) begin
          start     = 1'b1;
          xfer_byte = InitCmds[step_q];
          step_d    = step_q + 2'd1;
          if (step_q == 2'd3) begin
            state_d = StClrWait;
            wait_d  = '0;
          end
        end
      end
      // Counts from the Clear transfer's final cycle onward.
      StClrWait: begin
        if (ready) begin
          if (wait_q == WaitW'(CLR_WAIT - 1)) state_d = StRowAddr;
          else                                wait_d  = wait_q + WaitW'(1);
        end
      end
      StRowAddr: begin
`ifdef LCD_DIRTY_SKIP_EN
        if (dirty_q == '0) state_d = StIdle;
        else if (!dirty_q[row_q]) row_d = next_row;
        else
`endif
        if (ready) begin
          start     = 1'b1;
          xfer_byte = row_base(2'(row_q));
          col_d     = '0;
          state_d   = StChars;
        end
      end
      StChars: begin
        if (ready) begin
          start     = 1'b1;
          xfer_rs   = 1'b1;
          xfer_byte = char_q[row_q][col_q];
          if (col_q == ColW'(COLS - 1)) begin
            col_d   = '0;
            row_d   = next_row;
            state_d = StRowAddr;
            if (last_row) pend_d = 1'b1;
          end else begin
            col_d = col_q + ColW'(1);
          end
        end
      end
      default: begin
`ifdef LCD_DIRTY_SKIP_EN
        if (dirty_q != '0) state_d = StRowAddr;
`else
        state_d = StRowAddr;
`endif
      end
    endcase
  end

  always_ff @(posedge clk_LCD) begin
    if (!rst) begin
      state_q      <= StInit;
      step_q       <= 2'd0;
      row_q        <= '0;
      col_q        <= '0;
      wait_q       <= '0;
      busy_q       <= 1'b0;
      pend_q       <= 1'b0;
      frame_done_q <= 1'b0;
      wr_err_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      step_q       <= step_d;
      row_q        <= row_d;
      col_q        <= col_d;
      wait_q       <= wait_d;
      busy_q       <= start | (busy_q & ~phy_done);
      pend_q       <= pend_d;
      frame_done_q <= frame_done_d;
      wr_err_q     <= wr_hit & ~in_range;
    end
  end

  lcd_bus_phy #(
    .TICK (TICK)
  ) u_phy (
    .clk_LCD   (clk_LCD),
    .rst       (rst),
    .start     (start),
    .rs        (xfer_rs),
    .data_byte (xfer_byte),
    .LCD_EN    (LCD_EN),
    .RS        (RS),
    .DB8       (DB8),
    .done      (phy_done)
  );

  assign RW         = 1'b0;
  assign frame_done = frame_done_q;
  assign wr_err     = wr_err_q;

endmodule

// File: tb/tb_lcd_text_ctrl.sv
// Self-checking bench for lcd_text_ctrl: transfer-stream monitor against a write-log model.
module tb_lcd_text_ctrl;

  localparam int T        = 2;
  localparam int CW       = 8;
  localparam int NC       = 16;
  localparam int NR       = 2;
  localparam int FrameLen = NR * (NC + 1);

  logic        clk_LCD = 1'b0;
  logic        rst = 1'b0;
  logic        wr_en = 1'b0;
  logic [15:0] DEVICE = 16'h0000;
  logic [15:0] DATA = 16'h0000;
  logic        LCD_EN, RS, RW, frame_done, wr_err;
  logic [7:0]  DB8;

  lcd_text_ctrl #(
    .COLS     (NC),
    .ROWS     (NR),
    .DEV_ADDR (16'h0071),
    .TICK     (T),
    .CLR_WAIT (CW)
  ) dut (
    .clk_LCD    (clk_LCD),
    .rst        (rst),
    .wr_en      (wr_en),
    .DEVICE     (DEVICE),
    .DATA       (DATA),
    .LCD_EN     (LCD_EN),
    .RS         (RS),
    .RW         (RW),
    .DB8        (DB8),
    .frame_done (frame_done),
    .wr_err     (wr_err)
  );

  always #5 clk_LCD = ~clk_LCD;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  always @(posedge clk_LCD) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: ordered log of accepted writes, replayed up to a sample cycle.
  typedef struct {
    int         cyc;
    int         r;
    int         c;
    logic [7:0] ch;
  } wlog_t;
  wlog_t wlog[$];

  logic [7:0] init_cmds [4] = '{8'h38, 8'h0C, 8'h06, 8'h01};
  logic [7:0] base_tb   [4] = '{8'h80, 8'hC0, 8'h94, 8'hD4};

  function automatic logic [7:0] exp_char(input int r, input int c, input int s);
    logic [7:0] v = 8'h20;
    foreach (wlog[i]) begin
      if (wlog[i].cyc < s && wlog[i].r == r && wlog[i].c == c) v = wlog[i].ch;
    end
    return v;
  endfunction

  // Transfer monitor: one expected byte per LCD_EN rising edge.
  int         k, last_k, total, en_len, fd_cnt, last_rise, row0_rise, row0_cnt;
  int         mj, mp, mr, mc, pos;
  logic       en_prev;
  logic [8:0] mexp;

  always @(negedge clk_LCD) begin
    if (!rst) begin
      k = 0; en_prev = 1'b0; en_len = 0; fd_cnt = 0; last_k = -1;
    end else begin
      if (LCD_EN && !en_prev) begin
        if (k < 4) begin
          mexp = {1'b0, init_cmds[k]};
        end else begin
          mj = k - 4;
          mp = mj % FrameLen;
          mr = mp / (NC + 1);
          mc = mp % (NC + 1);
          if (mc == 0) mexp = {1'b0, base_tb[mr]};
          else         mexp = {1'b1, exp_char(mr, mc - 1, cyc - T - 1)};
          if (mj > 0 && mp == 0) check("frame_done_count", fd_cnt, mj / FrameLen);
          if (mp == 0) begin
            row0_rise = cyc;
            row0_cnt++;
          end
        end
        check($sformatf("xfer%0d_rs_db", k), {RS, DB8}, mexp);
        check("rw_low", RW, 1'b0);
        if (k > 0) check($sformatf("xfer%0d_gap", k), cyc - last_rise, (k == 4) ? 3*T + CW : 3*T);
        last_rise = cyc;
        last_k    = k;
        k++;
        total++;
        en_len = 1;
      end else if (LCD_EN) begin
        en_len++;
      end
      if (!LCD_EN && en_prev) check("en_width", en_len, T);
      if (frame_done) begin
        fd_cnt++;
        pos = (last_k >= 4) ? (last_k - 4) % FrameLen : -1;
        check("frame_done_pos", pos, FrameLen - 1);
        check("frame_done_time", cyc - last_rise, 2*T);
      end
      en_prev = LCD_EN;
    end
  end

  // Caller is at posedge+#1; returns at posedge+#1 after checking wr_err.
  task automatic bus_write(input logic [15:0] dev, input logic [15:0] data, input logic exp_err,
                           input string name);
    int r, c;
    r = int'(data[15:14]);
    c = int'(data[13:8]);
    wr_en  = 1'b1;
    DEVICE = dev;
    DATA   = data;
    if (dev == 16'h0071 && r < NR && c < NC) wlog.push_back('{cyc, r, c, data[7:0]});
    @(posedge clk_LCD); #1;
    wr_en = 1'b0;
    @(negedge clk_LCD);
    check(name, wr_err, exp_err);
    @(posedge clk_LCD); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk_LCD);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_en"}, LCD_EN, 1'b0);
    check({tag, "_rs"}, RS, 1'b0);
    check({tag, "_rw"}, RW, 1'b0);
    check({tag, "_db8"}, DB8, 8'h00);
    check({tag, "_fdone"}, frame_done, 1'b0);
    check({tag, "_werr"}, wr_err, 1'b0);
  endtask

  typedef struct {
    logic [15:0] dev;
    logic [15:0] data;
    logic        exp_err;
  } vec_t;
  vec_t tbl [8];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] dev, data;
    int          rr, cc, base, target;
    logic        seen;

    tbl[0] = '{16'h0071, 16'h4541, 1'b0};  // row1 col5 'A'
    tbl[1] = '{16'h0071, 16'h1041, 1'b1};  // col16 out of range
    tbl[2] = '{16'h0072, 16'h1041, 1'b0};  // other device
    tbl[3] = '{16'h0071, 16'h8042, 1'b1};  // row2 out of range
    tbl[4] = '{16'h0071, 16'hC343, 1'b1};  // row3
    tbl[5] = '{16'h0071, 16'h0F7E, 1'b0};  // row0 col15
    tbl[6] = '{16'h0072, 16'h0000, 1'b0};
    tbl[7] = '{16'h0071, 16'h4F55, 1'b0};  // row1 col15

    idle(3);
    @(negedge clk_LCD);
    check_reset_outputs("reset");
    @(posedge clk_LCD); #1;
    rst = 1'b1;

    // Init plus more than one untouched frame.
    idle(350);

    foreach (tbl[i]) begin
      bus_write(tbl[i].dev, tbl[i].data, tbl[i].exp_err, $sformatf("tbl%0d_wr_err", i));
      idle(3);
    end
    idle(450);

    for (int n = 0; n < 40; n++) begin
      dev  = ($urandom_range(0, 3) == 0) ? 16'h0072 : 16'h0071;
      rr   = $urandom_range(0, 2);
      cc   = $urandom_range(0, 18);
      data = {rr[1:0], cc[5:0], 8'($urandom_range(8'h21, 8'h7E))};
      bus_write(dev, data, (dev == 16'h0071) && (rr >= NR || cc >= NC), "rand_wr_err");
      idle($urandom_range(0, 15));
    end
    idle(450);

    // Write cell [0][3] in the very cycle its transfer samples the buffer.
    base = row0_cnt;
    for (int n = 0; n < 500 && row0_cnt == base; n++) idle(1);
    check("row0_addr_seen", row0_cnt != base, 1'b1);
    target = row0_rise + 4*3*T - T - 1;
    while (cyc < target) idle(1);
    bus_write(16'h0071, 16'h035A, 1'b0, "collide_wr_err");
    idle(2 * FrameLen * 3 * T + 20);

    // Reset in the middle of an enable pulse.
    seen = 1'b0;
    for (int n = 0; n < 100 && !seen; n++) begin
      @(negedge clk_LCD);
      seen = LCD_EN;
    end
    check("en_seen_before_reset", seen, 1'b1);
    @(posedge clk_LCD); #1;
    rst = 1'b0;
    wlog.delete();
    @(negedge clk_LCD);
    check("rst_en_same_cycle", LCD_EN, 1'b0);
    @(negedge clk_LCD);
    check("rst_en_next_cycle", LCD_EN, 1'b0);
    @(negedge clk_LCD);
    check_reset_outputs("midreset");
    @(posedge clk_LCD); #1;
    rst = 1'b1;
    idle(2 * FrameLen * 3 * T + 60);
    check("stream_after_reset", k >= 4 + 2 * FrameLen, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
